crc_frame_tx: RTL and testbench
===============================

// Module: crc_frame_tx
// PURPOSE
//  Parametrised serial frame transmitter with on-the-fly CRC and optional error injection.
//  Accepts a payload word plus error mode over a valid/ready handshake.
//  Serialises START, SYNC, DATA, CRC and STOP, MSB first, onto tx_line at CLKS_PER_BIT clocks per bit.
//  Sits between the input assembler and the GPIO Tx pin.
// PARAMETERS
//  DATA_W        8      payload width in bits (>=2)
//  CRC_W         8      CRC width in bits
//  CRC_POLY      8'h07  generator polynomial, implicit top bit
//  CRC_INIT      8'h00  CRC register value at frame start
//  SYNC_W        8      sync field width
//  SYNC_PAT      8'h7E  sync field pattern
//  CLKS_PER_BIT  434    clocks per line bit (>=2)
// PORTS
//  clk        in   1       system clock (CLOCK_50 domain)
//  rst_n      in   1       asynchronous active-low reset
//  tx_valid   in   1       payload offered
//  tx_ready   out  1       block can accept a payload
//  tx_data    in   DATA_W  payload
//  err_mode   in   2       00 none; 01 flip DATA MSB; 10 invert CRC; 11 flip DATA MSB and LSB
//  tx_line    out  1       serial line, idles high
//  tx_busy    out  1       frame in progress
//  tx_done    out  1       one-cycle pulse at end of STOP
// BEHAVIOUR
//  Reset: tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, counters 0.
//  - Reset is asynchronous. Reset mid-frame forces tx_line=1 immediately and abandons the frame.
//  Handshake: accept only when tx_valid && tx_ready at a rising edge.
//  - On accept, latch tx_data and err_mode, load CRC with CRC_INIT, enter START.
//  - tx_ready=0 and tx_busy=1 from the next cycle.
//  - tx_valid while busy is ignored and not queued. Data and mode changes after accept have no effect.
//  FSM: IDLE -> START -> SYNC -> DATA -> CRC -> STOP -> IDLE.
//  - Each bit is held exactly CLKS_PER_BIT clocks; the bit timer counts 0..CLKS_PER_BIT-1.
//  - Bit index and state advance when the bit timer reaches its terminal count.
//  - Field lengths: START=1, SYNC=SYNC_W, DATA=DATA_W, CRC=CRC_W, STOP=1 bit.
//  - Frame length = (2+SYNC_W+DATA_W+CRC_W)*CLKS_PER_BIT clocks. Latency is accept edge +1 clk to START low.
//  CRC:
//  - Serial MSB-first LFSR over the clean latched payload only; SYNC is excluded.
//  - Per payload bit d: fb = crc[MSB]^d; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
//  - Update occurs at each DATA bit's terminal count. CRC field sends the final register MSB first.
//  Error injection:
//  - The transmitted bit is XORed per err_mode; the CRC is always computed on uncorrupted data.
//  - The receiver therefore must detect mode 01, 10 and 11 frames as bad.
//  tx_done: asserts in the last clock of STOP. tx_ready rises the following cycle (IDLE).
//  - Back-to-back: a payload held valid is accepted in the first IDLE cycle, so there is exactly 1 idle-high clk between frames.
//  Widths: counters sized by $clog2; no wrap occurs because the index resets at each field end.
// CONFIGURATION
//  CRC_ERR_INJECT_EN
//  - Defined: err_mode is latched and applied as above.
//  - Undefined: err_mode is ignored, the error XOR path is removed, and every frame is clean.
//  - The port remains present in both builds.
// TESTING (DATA_W=8, CRC-8 0x07 init 0, SYNC 0x7E, CLKS_PER_BIT=4)
//  - Reset, then send 0x31 mode 00:
//    - 104-clk frame: line 0, then 7E, 31, CRC 97, then 1.
//    - tx_done pulses once; tx_ready returns high.
//  - Send 0x00 mode 00: CRC field 0x00. Each line bit stable 4 clks (sampled mid-bit).
//  - Send 0x31 mode 01: DATA field 0xB1, CRC 0x97. Mode 10: DATA 0x31, CRC 0x68. Mode 11: DATA 0xB0, CRC 0x97.
//    - Without CRC_ERR_INJECT_EN, all three modes give DATA 0x31, CRC 0x97.
//  - Hold tx_valid with 0x31 then 0x00:
//    - Two frames separated by exactly 1 high clk.
//    - tx_valid pulsed mid-frame is not accepted.
//  - Assert rst_n low during DATA bit 3:
//    - tx_line=1 asynchronously, tx_ready=1 after release, no tx_done.
//    - The next 0x31 frame is correct.

Source files
------------

// File: rtl/crc_frame_tx.sv
// Serial frame transmitter: START, SYNC, DATA, CRC, STOP, MSB first, CLKS_PER_BIT clocks per bit.
// Optional error injection on the transmitted bits is enabled by defining CRC_ERR_INJECT_EN.
module crc_frame_tx #(
   parameter int                DATA_W       = 8,
   parameter int                CRC_W        = 8,
   parameter logic [CRC_W-1:0]  CRC_POLY     = 8'h07,
   parameter logic [CRC_W-1:0]  CRC_INIT     = 8'h00,
   parameter int                SYNC_W       = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT     = 8'h7E,
   parameter int                CLKS_PER_BIT = 434
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [1:0]        err_mode,
   output logic              tx_line,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int MAX_AB = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int MAXF   = (MAX_AB > CRC_W) ? MAX_AB : CRC_W;
   localparam int IDX_W  = $clog2(MAXF);
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_W - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] CRC_LAST  = IDX_W'(CRC_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SYNC,
      S_DATA,
      S_CRC,
      S_STOP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [SYNC_W-1:0]  sync_q, sync_d;
   logic [CRC_W-1:0]   crc_q, crc_d;
   logic               bit_end;
   logic               accept;
   logic               crc_fb;
   logic               data_bit;
   logic               crc_bit;

   assign bit_end = (cnt_q == CNT_LAST);
   assign accept  = (state_q == S_IDLE) && tx_valid;
   assign crc_fb  = crc_q[CRC_W-1] ^ data_q[DATA_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         sync_q  <= '0;
         crc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         sync_q  <= sync_d;
         crc_q   <= crc_d;
      end
   end

   // Every field is a shift register consumed from its MSB; idx_q only marks the field end.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      sync_d  = sync_q;
      crc_d   = crc_q;

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = S_START;
               idx_d   = '0;
               data_d  = tx_data;
               sync_d  = SYNC_PAT;
               crc_d   = CRC_INIT;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_SYNC;
               idx_d   = '0;
            end
         end
         S_SYNC: begin
            if (bit_end) begin
               sync_d = sync_q << 1;
               if (idx_q == SYNC_LAST) begin
                  state_d = S_DATA;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (bit_end) begin
               // CRC always sees the clean payload bit, never the injected one.
               crc_d  = (crc_q << 1) ^ (crc_fb ? CRC_POLY : '0);
               data_d = data_q << 1;
               if (idx_q == DATA_LAST) begin
                  state_d = S_CRC;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_CRC: begin
            if (bit_end) begin
               crc_d = crc_q << 1;
               if (idx_q == CRC_LAST) begin
                  state_d = S_STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

`ifdef CRC_ERR_INJECT_EN
   logic [1:0] mode_q, mode_d;

   assign mode_d = accept ? err_mode : mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= 2'b00;
      end else begin
         mode_q <= mode_d;
      end
   end

   // 01 flips payload MSB, 11 flips MSB and LSB, 10 inverts the whole CRC field.
   assign data_bit = data_q[DATA_W-1]
                     ^ ((mode_q[0] && (idx_q == '0)) || ((mode_q == 2'b11) && (idx_q == DATA_LAST)));
   assign crc_bit  = crc_q[CRC_W-1] ^ (mode_q == 2'b10);
`else
   logic err_mode_unused;

   assign err_mode_unused = ^err_mode;
   assign data_bit        = data_q[DATA_W-1];
   assign crc_bit         = crc_q[CRC_W-1];
`endif

   always_comb begin
      tx_line = 1'b1;
      case (state_q)
         S_START: tx_line = 1'b0;
         S_SYNC:  tx_line = sync_q[SYNC_W-1];
         S_DATA:  tx_line = data_bit;
         S_CRC:   tx_line = crc_bit;
         default: tx_line = 1'b1;
      endcase
   end

   assign tx_ready = (state_q == S_IDLE);
   assign tx_busy  = (state_q != S_IDLE);
   assign tx_done  = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed self-checking bench for crc_frame_tx with CLKS_PER_BIT=4 (104-clock frames).
module tb_crc_frame_tx;

   logic       clk;
   logic       rst_n;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic [1:0] err_mode;
   logic       tx_line;
   logic       tx_busy;
   logic       tx_done;

   int n_assert = 0;
   int n_fail   = 0;

   logic line_s  [0:255];
   logic done_s  [0:255];
   logic ready_s [0:255];

`ifdef CRC_ERR_INJECT_EN
   localparam logic [7:0] M1_D = 8'hB1, M1_C = 8'h97;
   localparam logic [7:0] M2_D = 8'h31, M2_C = 8'h68;
   localparam logic [7:0] M3_D = 8'hB0, M3_C = 8'h97;
`else
   localparam logic [7:0] M1_D = 8'h31, M1_C = 8'h97;
   localparam logic [7:0] M2_D = 8'h31, M2_C = 8'h97;
   localparam logic [7:0] M3_D = 8'h31, M3_C = 8'h97;
`endif

   crc_frame_tx #(
      .DATA_W      (8),
      .CRC_W       (8),
      .CRC_POLY    (8'h07),
      .CRC_INIT    (8'h00),
      .SYNC_W      (8),
      .SYNC_PAT    (8'h7E),
      .CLKS_PER_BIT(4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_data (tx_data),
      .err_mode(err_mode),
      .tx_line (tx_line),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [25:0] exp_frame(input logic [7:0] d, input logic [7:0] c);
      return {1'b0, 8'h7E, d, c, 1'b1};
   endfunction

   // Mid-bit sample of each of the 26 bits starting at capture index off.
   function automatic logic [25:0] frame_at(input int off);
      logic [25:0] f;
      for (int k = 0; k < 26; k++) f[25-k] = line_s[off + 4*k + 1];
      return f;
   endfunction

   function automatic logic frame_stable(input int off);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 26; k++)
         for (int j = 0; j < 4; j++)
            if (line_s[off + 4*k + j] !== line_s[off + 4*k]) ok = 1'b0;
      return ok;
   endfunction

   function automatic int done_count(input int lo, input int hi);
      int c;
      c = 0;
      for (int i = lo; i <= hi; i++) if (done_s[i] === 1'b1) c++;
      return c;
   endfunction

   // Called at a negedge; returns just after the accepting posedge.
   task automatic start_frame(input logic [7:0] d, input logic [1:0] m, input bit hold);
      int k;
      tx_data  = d;
      err_mode = m;
      tx_valid = 1'b1;
      k = 0;
      while (tx_ready !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("accept_timeout", 32'(k < 300), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) begin
         tx_valid = 1'b0;
         tx_data  = ~d;
         err_mode = ~m;
      end
   endtask

   task automatic capture(input int n, input int pulse_at, input int drop_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         line_s[i]  = tx_line;
         done_s[i]  = tx_done;
         ready_s[i] = tx_ready;
         if (i == pulse_at) begin
            tx_valid = 1'b1;
            tx_data  = 8'hFF;
         end
         if (i == pulse_at + 1 || i == drop_at) tx_valid = 1'b0;
      end
   endtask

   task automatic frame_test(input string tag, input logic [7:0] d, input logic [1:0] m,
                             input logic [7:0] exp_d, input logic [7:0] exp_c);
      start_frame(d, m, 1'b0);
      capture(106, -10, -1);
      check({tag, "_bits"}, 32'(frame_at(0)), 32'(exp_frame(exp_d, exp_c)));
      check({tag, "_stable"}, 32'(frame_stable(0)), 32'd1);
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      err_mode = 2'b00;

      @(negedge clk);
      check("reset_state", {28'd0, tx_line, tx_ready, tx_busy, tx_done}, 32'b1100);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Clean frame 0x31: CRC 0x97, single done in the last clock, ready back afterwards.
      start_frame(8'h31, 2'b00, 1'b0);
      check("busy_after_accept", {30'd0, tx_busy, tx_ready}, 32'b10);
      capture(106, -10, -1);
      $display("frame 0x31 mode 00: line bits %b", frame_at(0));
      check("f31_bits", 32'(frame_at(0)), 32'(exp_frame(8'h31, 8'h97)));
      check("f31_stable", 32'(frame_stable(0)), 32'd1);
      check("f31_done_count", 32'(done_count(0, 105)), 32'd1);
      check("f31_done_last", 32'(done_s[103]), 32'd1);
      check("f31_ready_during", 32'(ready_s[103]), 32'd0);
      check("f31_ready_after", {30'd0, ready_s[104], line_s[104]}, 32'b11);

      // 0x00 frame with a tx_valid pulse mid-frame that must be ignored.
      start_frame(8'h00, 2'b00, 1'b0);
      capture(112, 50, -1);
      $display("frame 0x00 mode 00: line bits %b", frame_at(0));
      check("f00_bits", 32'(frame_at(0)), 32'(exp_frame(8'h00, 8'h00)));
      check("f00_stable", 32'(frame_stable(0)), 32'd1);
      begin
         logic idle_ok;
         idle_ok = 1'b1;
         for (int i = 104; i < 112; i++)
            if (line_s[i] !== 1'b1 || ready_s[i] !== 1'b1) idle_ok = 1'b0;
         check("pulse_ignored_idle", 32'(idle_ok), 32'd1);
      end

      frame_test("mode01", 8'h31, 2'b01, M1_D, M1_C);
      $display("frame 0x31 mode 01: line bits %b", frame_at(0));
      frame_test("mode10", 8'h31, 2'b10, M2_D, M2_C);
      $display("frame 0x31 mode 10: line bits %b", frame_at(0));
      frame_test("mode11", 8'h31, 2'b11, M3_D, M3_C);
      $display("frame 0x31 mode 11: line bits %b", frame_at(0));

      // Back-to-back: valid held, data changed to 0x00 right after the first accept.
      start_frame(8'h31, 2'b00, 1'b1);
      tx_data = 8'h00;
      capture(212, -10, 105);
      $display("back-to-back: frame1 %b frame2 %b", frame_at(0), frame_at(105));
      check("b2b_f1_bits", 32'(frame_at(0)), 32'(exp_frame(8'h31, 8'h97)));
      check("b2b_f2_bits", 32'(frame_at(105)), 32'(exp_frame(8'h00, 8'h00)));
      check("b2b_gap", {29'd0, line_s[103], line_s[104], line_s[105]}, 32'b110);
      check("b2b_ready_gap", {29'd0, ready_s[103], ready_s[104], ready_s[105]}, 32'b010);
      check("b2b_done_count", 32'(done_count(0, 211)), 32'd2);

      // Asynchronous reset during DATA bit 3 (capture cycles 48..51).
      start_frame(8'h00, 2'b00, 1'b0);
      capture(50, -10, -1);
      check("rst_pre_line", 32'(tx_line), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_line", 32'(tx_line), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      capture(20, -10, -1);
      $display("reset mid-frame: done pulses after release %0d", done_count(0, 19));
      check("rst_no_done", 32'(done_count(0, 19)), 32'd0);
      check("rst_ready_after", {30'd0, ready_s[0], line_s[19]}, 32'b11);

      frame_test("post_rst", 8'h31, 2'b00, 8'h31, 8'h97);
      $display("frame 0x31 after reset: line bits %b", frame_at(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
